// File: rtl/vproc_dispatcher.sv
// vproc_dispatcher: single-entry in-order issue stage. Holds one decoded instruction,
// checks vector-register hazards against a per-ID scoreboard and hands it to one unit.
module vproc_dispatcher #(
   parameter int unsigned ID_W = 3
) (
   input  logic            clk_i,
   input  logic            sync_rst_i,
   input  logic            instr_valid_i,
   output logic            instr_ready_o,
   input  logic [2:0]      instr_unit_i,
   input  logic [ID_W-1:0] instr_id_i,
   input  logic [1:0]      instr_emul_i,
   input  logic            instr_vs1_vreg_i,
   input  logic [4:0]      instr_vs1_i,
   input  logic            instr_vs2_vreg_i,
   input  logic [4:0]      instr_vs2_i,
   input  logic            instr_vd_vreg_i,
   input  logic [4:0]      instr_vd_i,
   input  logic            instr_masked_i,
   output logic [4:0]      unit_valid_o,
   input  logic [4:0]      unit_ready_i,
   output logic [ID_W-1:0] unit_id_o,
   output logic            cfg_valid_o,
   input  logic            cfg_ready_i,
   input  logic            done_valid_i,
   input  logic [ID_W-1:0] done_id_i,
   output logic            busy_o
);

   localparam int unsigned N_ID     = 1 << ID_W;
   localparam logic [2:0]  UNIT_CFG = 3'd5;

   // Register group span starting at addr; bits past v31 fall off the top of the shift.
   function automatic logic [31:0] group_mask(input logic [4:0] addr, input logic [1:0] emul);
      logic [31:0] span;
      case (emul)
         2'd0:    span = 32'h0000_0001;
         2'd1:    span = 32'h0000_0003;
         2'd2:    span = 32'h0000_000F;
         2'd3:    span = 32'h0000_00FF;
         default: span = 32'h0000_0001;
      endcase
      return span << addr;
   endfunction

   logic            hold_valid_r;
   logic [2:0]      hold_unit_r;
   logic [ID_W-1:0] hold_id_r;
   logic [31:0]     hold_rd_r;
   logic [31:0]     hold_wr_r;

   logic [N_ID-1:0] id_busy_r;
   logic [31:0]     rd_mask_r [N_ID];
   logic [31:0]     wr_mask_r [N_ID];

   logic [31:0]     pend_rd_s;
   logic [31:0]     pend_wr_s;
   logic [31:0]     in_rd_s;
   logic [31:0]     in_wr_s;
   logic            hazard_s;
   logic [4:0]      unit_valid_s;
   logic            cfg_valid_s;
   logic            fire_s;
   logic            alloc_s;
   logic            instr_ready_s;
   logic            accept_s;

   // Pending read/write footprint of all outstanding instructions
   always_comb begin
      pend_rd_s = 32'h0;
      pend_wr_s = 32'h0;
      for (int i = 0; i < N_ID; i++) begin
         if (id_busy_r[i]) begin
            pend_rd_s = pend_rd_s | rd_mask_r[i];
            pend_wr_s = pend_wr_s | wr_mask_r[i];
         end else begin
            pend_rd_s = pend_rd_s;
            pend_wr_s = pend_wr_s;
         end
      end
   end

   // Register footprint of the incoming instruction, computed once at capture
   always_comb begin
      in_rd_s = {31'h0, instr_masked_i};
      in_wr_s = 32'h0;
      if (instr_vs1_vreg_i) begin
         in_rd_s = in_rd_s | group_mask(instr_vs1_i, instr_emul_i);
      end else begin
         in_rd_s = in_rd_s;
      end
      if (instr_vs2_vreg_i) begin
         in_rd_s = in_rd_s | group_mask(instr_vs2_i, instr_emul_i);
      end else begin
         in_rd_s = in_rd_s;
      end
      if (instr_vd_vreg_i) begin
         in_wr_s = group_mask(instr_vd_i, instr_emul_i);
      end else begin
         in_wr_s = 32'h0;
      end
   end

   // Hazard check and dispatch handshake for the held instruction
   always_comb begin
      hazard_s = (|(hold_rd_r & pend_wr_s))
               | (|(hold_wr_r & (pend_wr_s | pend_rd_s)))
               | id_busy_r[hold_id_r]
               | (hold_unit_r > UNIT_CFG);
      unit_valid_s = 5'b0;
      if (hold_valid_r && !hazard_s && (hold_unit_r < UNIT_CFG)) begin
         unit_valid_s[hold_unit_r] = 1'b1;
      end else begin
         unit_valid_s = 5'b0;
      end
      cfg_valid_s   = hold_valid_r & (hold_unit_r == UNIT_CFG) & ~(|id_busy_r);
      fire_s        = (|(unit_valid_s & unit_ready_i)) | (cfg_valid_s & cfg_ready_i);
      alloc_s       = fire_s & (hold_unit_r != UNIT_CFG);
      instr_ready_s = ~sync_rst_i & (~hold_valid_r | fire_s);
      accept_s      = instr_valid_i & instr_ready_s;
   end

   // Holding register: refill takes priority over the clear on fire
   always_ff @(posedge clk_i) begin
      if (sync_rst_i) begin
         hold_valid_r <= 1'b0;
         hold_unit_r  <= 3'd0;
         hold_id_r    <= '0;
         hold_rd_r    <= 32'h0;
         hold_wr_r    <= 32'h0;
      end else if (accept_s) begin
         hold_valid_r <= 1'b1;
         hold_unit_r  <= instr_unit_i;
         hold_id_r    <= instr_id_i;
         hold_rd_r    <= in_rd_s;
         hold_wr_r    <= in_wr_s;
      end else if (fire_s) begin
         hold_valid_r <= 1'b0;
      end else begin
         hold_valid_r <= hold_valid_r;
      end
   end

   // Scoreboard: allocate on dispatch, release on completion of a busy ID
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < N_ID; i++) begin
         if (sync_rst_i) begin
            id_busy_r[i] <= 1'b0;
            rd_mask_r[i] <= 32'h0;
            wr_mask_r[i] <= 32'h0;
         end else if (alloc_s && (hold_id_r == ID_W'(i))) begin
            id_busy_r[i] <= 1'b1;
            rd_mask_r[i] <= hold_rd_r;
            wr_mask_r[i] <= hold_wr_r;
         end else if (done_valid_i && (done_id_i == ID_W'(i)) && id_busy_r[i]) begin
            id_busy_r[i] <= 1'b0;
            rd_mask_r[i] <= 32'h0;
            wr_mask_r[i] <= 32'h0;
         end else begin
            id_busy_r[i] <= id_busy_r[i];
         end
      end
   end

   assign instr_ready_o = instr_ready_s;
   assign unit_valid_o  = unit_valid_s;
   assign cfg_valid_o   = cfg_valid_s;
   assign unit_id_o     = hold_id_r;
   assign busy_o        = hold_valid_r | (|id_busy_r);

endmodule

// File: tb/tb_vproc_dispatcher.sv
// Self-checking bench for vproc_dispatcher: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a register-set reference model.
module tb_vproc_dispatcher;

   localparam int ID_W = 3;
   localparam int N_ID = 1 << ID_W;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            sync_rst;
   logic            instr_valid;
   logic            instr_ready;
   logic [2:0]      instr_unit;
   logic [ID_W-1:0] instr_id;
   logic [1:0]      instr_emul;
   logic            vs1_vreg, vs2_vreg, vd_vreg, masked;
   logic [4:0]      vs1, vs2, vd;
   logic [4:0]      unit_valid;
   logic [4:0]      unit_ready;
   logic [ID_W-1:0] unit_id;
   logic            cfg_valid, cfg_ready;
   logic            done_valid;
   logic [ID_W-1:0] done_id;
   logic            busy;

   vproc_dispatcher #(.ID_W(ID_W)) dut (
      .clk_i(clk), .sync_rst_i(sync_rst),
      .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
      .instr_unit_i(instr_unit), .instr_id_i(instr_id), .instr_emul_i(instr_emul),
      .instr_vs1_vreg_i(vs1_vreg), .instr_vs2_vreg_i(vs2_vreg),
      .instr_vs1_i(vs1), .instr_vs2_i(vs2),
      .instr_vd_vreg_i(vd_vreg), .instr_vd_i(vd), .instr_masked_i(masked),
      .unit_valid_o(unit_valid), .unit_ready_i(unit_ready), .unit_id_o(unit_id),
      .cfg_valid_o(cfg_valid), .cfg_ready_i(cfg_ready),
      .done_valid_i(done_valid), .done_id_i(done_id), .busy_o(busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: held instruction as register sets, outstanding sets per ID
   bit          m_hold_valid;
   int          m_unit, m_id;
   logic [31:0] m_hold_rd, m_hold_wr;
   bit          m_busy [N_ID];
   logic [31:0] m_rd [N_ID];
   logic [31:0] m_wr [N_ID];
   logic [4:0]  e_unit_valid;
   bit          e_cfg, e_ready, e_busy, e_fire;

   function automatic logic [31:0] regset(input bit is_vreg, input int base, input int emul);
      logic [31:0] s;
      s = 32'h0;
      if (is_vreg)
         for (int r = base; r < base + (1 << emul); r++)
            if (r < 32) s[r] = 1'b1;
      return s;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_hold_valid = 1'b0;
      m_unit = 0;
      m_id = 0;
      m_hold_rd = 32'h0;
      m_hold_wr = 32'h0;
      for (int j = 0; j < N_ID; j++) begin
         m_busy[j] = 1'b0;
         m_rd[j] = 32'h0;
         m_wr[j] = 32'h0;
      end
   endtask

   // Settle, derive expected outputs from the model, compare against the DUT
   task automatic sample();
      bit haz, any_busy;
      #1;
      haz = 1'b0;
      any_busy = 1'b0;
      for (int j = 0; j < N_ID; j++) begin
         if (m_busy[j]) begin
            any_busy = 1'b1;
            if ((m_hold_rd & m_wr[j]) != 32'h0) haz = 1'b1;
            if ((m_hold_wr & (m_wr[j] | m_rd[j])) != 32'h0) haz = 1'b1;
         end
      end
      if (m_busy[m_id]) haz = 1'b1;
      if (m_unit > 5) haz = 1'b1;
      e_unit_valid = 5'b0;
      if (m_hold_valid && !haz && m_unit < 5) e_unit_valid = 5'(1 << m_unit);
      e_cfg   = m_hold_valid && (m_unit == 5) && !any_busy;
      e_fire  = ((m_unit < 5) && (e_unit_valid != 5'b0) && unit_ready[m_unit]) || (e_cfg && cfg_ready);
      e_ready = !sync_rst && (!m_hold_valid || e_fire);
      e_busy  = m_hold_valid || any_busy;
      check("unit_valid", 32'(unit_valid), 32'(e_unit_valid));
      check("cfg_valid", 32'(cfg_valid), 32'(e_cfg));
      check("instr_ready", 32'(instr_ready), 32'(e_ready));
      check("busy", 32'(busy), 32'(e_busy));
      if (m_hold_valid) check("unit_id", 32'(unit_id), 32'(m_id));
   endtask

   // Apply this cycle's inputs to the model, then cross the clock edge
   task automatic advance();
      if (sync_rst) begin
         model_clear();
      end else begin
         if (done_valid && m_busy[int'(done_id)]) begin
            m_busy[int'(done_id)] = 1'b0;
            m_rd[int'(done_id)] = 32'h0;
            m_wr[int'(done_id)] = 32'h0;
         end
         if (e_fire && m_unit != 5) begin
            m_busy[m_id] = 1'b1;
            m_rd[m_id] = m_hold_rd;
            m_wr[m_id] = m_hold_wr;
         end
         if (instr_valid && e_ready) begin
            m_hold_valid = 1'b1;
            m_unit = int'(instr_unit);
            m_id = int'(instr_id);
            m_hold_rd = regset(vs1_vreg, int'(vs1), int'(instr_emul))
                      | regset(vs2_vreg, int'(vs2), int'(instr_emul))
                      | (masked ? 32'h1 : 32'h0);
            m_hold_wr = regset(vd_vreg, int'(vd), int'(instr_emul));
         end else if (e_fire) begin
            m_hold_valid = 1'b0;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      instr_valid = 1'b0; instr_unit = 3'd0; instr_id = '0; instr_emul = 2'd0;
      vs1_vreg = 1'b0; vs2_vreg = 1'b0; vd_vreg = 1'b0; masked = 1'b0;
      vs1 = 5'd0; vs2 = 5'd0; vd = 5'd0;
      unit_ready = 5'b11111; cfg_ready = 1'b1;
      done_valid = 1'b0; done_id = '0;
   endtask

   task automatic set_instr(input int u, input int id, input int emul,
                            input bit v1v, input int v1, input bit v2v, input int v2,
                            input bit vdv, input int d, input bit m);
      instr_valid = 1'b1; instr_unit = 3'(u); instr_id = ID_W'(id); instr_emul = 2'(emul);
      vs1_vreg = v1v; vs1 = 5'(v1); vs2_vreg = v2v; vs2 = 5'(v2);
      vd_vreg = vdv; vd = 5'(d); masked = m;
   endtask

   task automatic do_reset();
      idle();
      sync_rst = 1'b1;
      sample();
      check("rst_ready_low", 32'(instr_ready), 32'd0);
      advance();
      sync_rst = 1'b0;
      sample();
      check("rst_unit_valid", 32'(unit_valid), 32'd0);
      check("rst_cfg_valid", 32'(cfg_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_unit_id", 32'(unit_id), 32'd0);
      check("rst_ready_high", 32'(instr_ready), 32'd1);
   endtask

   initial begin
      model_clear();
      idle();
      sync_rst = 1'b1;
      @(posedge clk);
      @(negedge clk);

      // Independent ops back to back
      do_reset();
      set_instr(1, 0, 0, 0, 0, 0, 0, 1, 4, 0); advance();
      set_instr(2, 1, 0, 0, 0, 1, 8, 1, 12, 0); sample();
      check("indep_alu_valid", 32'(unit_valid), 32'b00010);
      check("indep_ready", 32'(instr_ready), 32'd1);
      advance();
      instr_valid = 1'b0; sample();
      check("indep_mul_valid", 32'(unit_valid), 32'b00100);
      advance();

      // RAW on a four-register group
      do_reset();
      set_instr(0, 0, 2, 0, 0, 0, 0, 1, 8, 0); advance();
      set_instr(1, 1, 0, 0, 0, 1, 10, 0, 0, 0); sample();
      check("raw_lsu_valid", 32'(unit_valid), 32'b00001);
      advance();
      instr_valid = 1'b0;
      repeat (3) begin sample(); check("raw_stall", 32'(unit_valid), 32'd0); advance(); end
      done_valid = 1'b1; done_id = ID_W'(0); sample();
      check("raw_no_bypass", 32'(unit_valid), 32'd0);
      advance();
      done_valid = 1'b0; sample();
      check("raw_release", 32'(unit_valid), 32'b00010);
      advance();

      // WAR against a masked read of v0
      do_reset();
      set_instr(2, 2, 0, 0, 0, 0, 0, 0, 0, 1); advance();
      set_instr(1, 3, 0, 0, 0, 0, 0, 1, 0, 0); sample();
      check("war_mul_valid", 32'(unit_valid), 32'b00100);
      advance();
      instr_valid = 1'b0;
      repeat (2) begin
         sample();
         check("war_stall", 32'(unit_valid), 32'd0);
         check("war_ready_low", 32'(instr_ready), 32'd0);
         advance();
      end
      done_valid = 1'b1; done_id = ID_W'(2); sample(); advance();
      done_valid = 1'b0; sample();
      check("war_release", 32'(unit_valid), 32'b00010);
      advance();

      // CFG barrier
      do_reset();
      set_instr(1, 0, 0, 0, 0, 0, 0, 1, 1, 0); advance();
      set_instr(1, 1, 0, 0, 0, 0, 0, 1, 2, 0); sample(); advance();
      set_instr(5, 4, 0, 0, 0, 0, 0, 0, 0, 0); sample(); advance();
      instr_valid = 1'b0; done_valid = 1'b1; done_id = ID_W'(0); sample();
      check("cfg_wait2", 32'(cfg_valid), 32'd0);
      advance();
      done_id = ID_W'(1); sample();
      check("cfg_wait1", 32'(cfg_valid), 32'd0);
      advance();
      done_valid = 1'b0; sample();
      check("cfg_go", 32'(cfg_valid), 32'd1);
      advance();
      sample();
      check("cfg_drained", 32'(busy), 32'd0);
      advance();

      // ID reuse and clipped group at v30
      do_reset();
      set_instr(1, 0, 3, 0, 0, 0, 0, 1, 30, 0); advance();
      set_instr(2, 1, 0, 1, 0, 0, 0, 0, 0, 0); sample(); advance();
      set_instr(1, 0, 0, 0, 0, 0, 0, 1, 5, 0); sample();
      check("clip_v0_no_stall", 32'(unit_valid), 32'b00100);
      advance();
      instr_valid = 1'b0; done_valid = 1'b1; done_id = ID_W'(0); sample();
      check("reuse_stall", 32'(unit_valid), 32'd0);
      advance();
      done_valid = 1'b0; sample();
      check("reuse_release", 32'(unit_valid), 32'b00010);
      advance();

      // Reset in the middle of activity
      do_reset();
      set_instr(1, 0, 0, 0, 0, 0, 0, 1, 1, 0); advance();
      set_instr(1, 1, 0, 0, 0, 0, 0, 1, 2, 0); sample(); advance();
      set_instr(2, 2, 0, 0, 0, 0, 0, 1, 3, 0); sample(); advance();
      set_instr(1, 0, 0, 0, 0, 0, 0, 1, 4, 0); sample(); advance();
      instr_valid = 1'b0; sample();
      check("mid_held_stall", 32'(unit_valid), 32'd0);
      advance();
      sync_rst = 1'b1; sample(); advance();
      sync_rst = 1'b0;
      done_valid = 1'b1; done_id = ID_W'(1);
      set_instr(1, 1, 0, 0, 0, 0, 0, 1, 6, 0); sample();
      check("mid_rst_valid", 32'(unit_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      advance();
      done_valid = 1'b0; instr_valid = 1'b0; sample();
      check("mid_new_dispatch", 32'(unit_valid), 32'b00010);
      advance();

      // Illegal unit code parks the holding register
      do_reset();
      set_instr(6, 5, 0, 0, 0, 0, 0, 0, 0, 0); advance();
      instr_valid = 1'b0;
      repeat (3) begin
         sample();
         check("illegal_no_valid", 32'({cfg_valid, unit_valid}), 32'd0);
         advance();
      end

      // Randomized traffic
      do_reset();
      advance();
      for (int c = 0; c < 4000; c++) begin
         instr_valid = ($urandom_range(0, 3) != 0);
         instr_unit  = 3'($urandom_range(0, 5));
         instr_id    = ID_W'($urandom_range(0, N_ID - 1));
         instr_emul  = 2'($urandom_range(0, 3));
         vs1_vreg = 1'($urandom_range(0, 1)); vs1 = 5'($urandom_range(0, 31));
         vs2_vreg = 1'($urandom_range(0, 1)); vs2 = 5'($urandom_range(0, 31));
         vd_vreg  = 1'($urandom_range(0, 1)); vd  = 5'($urandom_range(0, 31));
         masked   = ($urandom_range(0, 3) == 0);
         unit_ready = 5'($urandom);
         cfg_ready  = 1'($urandom_range(0, 1));
         done_valid = ($urandom_range(0, 2) == 0);
         done_id    = ID_W'($urandom_range(0, N_ID - 1));
         sync_rst   = ($urandom_range(0, 199) == 0);
         sample();
         advance();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
